// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide), one bit per cycle.
// Optional macro MUL_DIV_FAST_MUL_EN: single-cycle combinational multiply for MUL/MULU.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_m;
  logic [WIDTH-1:0] r_outHi, r_outLo;
  logic             r_isDiv, r_negQ, r_negR, r_dbz, r_outDbz;

  logic             w_accept, w_anyOp, w_isMul, w_isMulu, w_isDiv, w_isDivu;
  logic             w_signed, w_neg1, w_neg2, w_fastGo;
  logic [WIDTH-1:0] w_mag1, w_mag2;

  assign in_ready  = (r_state == IDLE) & ~cancel;
  assign out_valid = (r_state == DONE);
  assign out_hi    = r_outHi;
  assign out_lo    = r_outLo;
  assign out_dbz   = r_outDbz;

  assign w_accept = in_valid & in_ready;
  assign w_anyOp  = |in_op;
  assign w_isMul  = in_op[0];
  assign w_isMulu = ~in_op[0] & in_op[1];
  assign w_isDiv  = ~in_op[0] & ~in_op[1] & in_op[2];
  assign w_isDivu = ~(|in_op[2:0]) & in_op[3];
  assign w_signed = w_isMul | w_isDiv;
  assign w_neg1   = w_signed & in_src1[WIDTH-1];
  assign w_neg2   = w_signed & in_src2[WIDTH-1];
  assign w_mag1   = w_neg1 ? -in_src1 : in_src1;
  assign w_mag2   = w_neg2 ? -in_src2 : in_src2;

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext1, w_ext2, w_fastProd;
  assign w_fastGo   = w_isMul | w_isMulu;
  assign w_ext1     = {{WIDTH{w_isMul & in_src1[WIDTH-1]}}, in_src1};
  assign w_ext2     = {{WIDTH{w_isMul & in_src2[WIDTH-1]}}, in_src2};
  assign w_fastProd = w_ext1 * w_ext2;
`else
  assign w_fastGo = 1'b0;
`endif

  // Multiply step: conditionally add multiplicand into hi, then shift {hi,lo} right.
  logic [WIDTH:0] w_addSum;
  assign w_addSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

  // Divide step: lo shifts the dividend out while quotient bits shift in.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});
  assign w_diff  = w_shift[WIDTH-1:0] - r_m;

  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0]   w_quoFix, w_remFix;
  assign w_prod    = {r_hi, r_lo};
  assign w_prodFix = r_negQ ? -w_prod : w_prod;
  assign w_quoFix  = r_dbz ? '1 : (r_negQ ? -r_lo : r_lo);
  assign w_remFix  = r_negR ? -r_hi : r_hi;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_anyOp) w_next = w_fastGo ? DONE : CALC;
      CALC:    if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (cancel) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_isDiv  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_dbz    <= 1'b0;
      r_outHi  <= '0;
      r_outLo  <= '0;
      r_outDbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept && w_anyOp) begin
          r_cnt   <= CW'(WIDTH);
          r_hi    <= '0;
          r_lo    <= w_mag1;
          r_m     <= w_mag2;
          r_isDiv <= w_isDiv | w_isDivu;
          r_negQ  <= w_neg1 ^ w_neg2;
          r_negR  <= w_neg1;
          r_dbz   <= (w_isDiv | w_isDivu) & (in_src2 == '0);
`ifdef MUL_DIV_FAST_MUL_EN
          if (w_fastGo) begin
            r_outHi  <= w_fastProd[2*WIDTH-1:WIDTH];
            r_outLo  <= w_fastProd[WIDTH-1:0];
            r_outDbz <= 1'b0;
          end
`endif
        end
        CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_isDiv) begin
            r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_addSum[WIDTH:1];
            r_lo <= {w_addSum[0], r_lo[WIDTH-1:1]};
          end
        end
        // A flush in the sign-fix cycle must leave the previous result untouched.
        FIX: if (!cancel) begin
          r_outHi  <= r_isDiv ? w_remFix : w_prodFix[2*WIDTH-1:WIDTH];
          r_outLo  <= r_isDiv ? w_quoFix : w_prodFix[WIDTH-1:0];
          r_outDbz <= r_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule
